// File: rtl/tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_4ch
//  Purpose  : Receive-side demultiplexer for a 4:1 slot-multiplexed link.
//             Each valid beat carries one W-bit slot sample. A start-of-frame
//             marker on the slot-0 beat establishes alignment. Slots 0..2 are
//             collected in shadow registers, and the slot-3 beat commits a
//             whole frame to the channel outputs in a single update.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1    rising-edge clock
//    rst_n        in   1    asynchronous active-low reset
//    din          in   W    slot sample
//    din_valid    in   1    din valid this cycle (one beat = one slot)
//    sof          in   1    start of frame, qualified by din_valid
//    y            out  4W   channel outputs, ch0 in LSBs (registered)
//    frame_valid  out  1    one-cycle pulse: y holds a new complete frame
//    sync_err     out  1    one-cycle pulse: framing violation detected
//    locked       out  1    high while frame alignment is held
//    slot         out  2    slot expected for the next beat (0 while hunting)
// ============================================================================
module tdm_demux_4ch #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [4*W-1:0] y,
  output logic           frame_valid,
  output logic           sync_err,
  output logic           locked,
  output logic [1:0]     slot
);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_SYNC = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_slot,  w_slot_nxt;
  logic [W-1:0]   r_sh0,   w_sh0_nxt;
  logic [W-1:0]   r_sh1,   w_sh1_nxt;
  logic [W-1:0]   r_sh2,   w_sh2_nxt;
  logic [4*W-1:0] r_y,     w_y_nxt;
  logic           r_fv,    w_fv_nxt;
  logic           r_err,   w_err_nxt;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_slot  <= 2'd0;
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_y     <= '0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_sh0   <= w_sh0_nxt;
      r_sh1   <= w_sh1_nxt;
      r_sh2   <= w_sh2_nxt;
      r_y     <= w_y_nxt;
      r_fv    <= w_fv_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Everything holds by default; the pulses default low so
  // an idle cycle only clears them.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_sh0_nxt   = r_sh0;
    w_sh1_nxt   = r_sh1;
    w_sh2_nxt   = r_sh2;
    w_y_nxt     = r_y;
    w_fv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;

    if (din_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          // Only a marked beat can establish alignment; anything else is dropped.
          if (sof) begin
            w_sh0_nxt   = din;
            w_slot_nxt  = 2'd1;
            w_state_nxt = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (sof) begin
            // A marker is always honoured as slot 0. If it arrives mid-frame,
            // the partial frame is abandoned and an error is flagged, but
            // alignment is kept because the marker itself is trustworthy.
            w_err_nxt  = (r_slot != 2'd0);
            w_sh0_nxt  = din;
            w_slot_nxt = 2'd1;
          end else begin
            unique case (r_slot)
              2'd0: begin
                // Slot 0 arrived without its marker, so alignment is lost.
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_HUNT;
                w_slot_nxt  = 2'd0;
              end
              2'd1: begin
                w_sh1_nxt  = din;
                w_slot_nxt = 2'd2;
              end
              2'd2: begin
                w_sh2_nxt  = din;
                w_slot_nxt = 2'd3;
              end
              2'd3: begin
                // Commit all four channels together so consumers never see
                // a mix of samples from two frames.
                w_y_nxt    = {din, r_sh2, r_sh1, r_sh0};
                w_fv_nxt   = 1'b1;
                w_slot_nxt = 2'd0;
              end
              default: begin
                w_slot_nxt = 2'd0;
              end
            endcase
          end
        end

        default: begin
          w_state_nxt = ST_HUNT;
          w_slot_nxt  = 2'd0;
        end
      endcase
    end
  end

  assign y           = r_y;
  assign frame_valid = r_fv;
  assign sync_err    = r_err;
  assign locked      = (r_state == ST_SYNC);
  assign slot        = r_slot;

endmodule
`default_nettype wire
